// File: rtl/block_storage_if.sv
// Write channel carrying block-header words into block_storage.
// writeValid qualifies blockData for the current cycle.
interface blockStoreIfc #(
  parameter int WORD_WIDTH = 32
);
  logic                  writeValid;
  logic [WORD_WIDTH-1:0] blockData;

  modport writer (
    output writeValid,
    output blockData
  );

  modport reader (
    input writeValid,
    input blockData
  );
endinterface

// File: rtl/block_storage.sv
// Assembles NUM_WORDS header words into one committed block state.
// Ports: clk, rst (async active-low), blkRd (word channel),
//        validOut, newBlock (commit pulse), initialState.
module block_storage #(
  parameter int WORD_WIDTH  = 32,
  parameter int NUM_WORDS   = 11,
  parameter int STATE_WIDTH = WORD_WIDTH * NUM_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  blockStoreIfc.reader           blkRd,
  output logic                   validOut,
  output logic                   newBlock,
  output logic [STATE_WIDTH-1:0] initialState
);

  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  logic [STATE_WIDTH-1:0] buffer;
  logic [CW-1:0]          count;
  logic [STATE_WIDTH-1:0] shifted;

  // Buffer after accepting the current word; on the last word this
  // is exactly the completed block, so it also feeds the commit.
  assign shifted = {buffer[STATE_WIDTH-WORD_WIDTH-1:0], blkRd.blockData};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer       <= '0;
      count        <= '0;
      initialState <= '0;
      validOut     <= 1'b0;
      newBlock     <= 1'b0;
    end else begin
      newBlock <= 1'b0;
      if (blkRd.writeValid) begin
        buffer <= shifted;
        if (count == LAST) begin
          count        <= '0;
          initialState <= shifted;
          validOut     <= 1'b1;
          newBlock     <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_block_storage.sv
// Directed self-checking bench for block_storage.
// Steps drive at negedge; outputs sampled 1ns after posedge.
module tb_block_storage;

  localparam int WW = 32;
  localparam int NW = 11;
  localparam int SW = WW * NW;

  logic          clk;
  logic          rst;
  logic          validOut;
  logic          newBlock;
  logic [SW-1:0] initialState;

  int errors = 0;
  int checks = 0;

  blockStoreIfc #(.WORD_WIDTH(WW)) ifc ();

  block_storage #(
    .WORD_WIDTH(WW),
    .NUM_WORDS (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .blkRd       (ifc),
    .validOut    (validOut),
    .newBlock    (newBlock),
    .initialState(initialState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [SW-1:0] obs,
                       input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic vo,
                      input logic nb, input logic [SW-1:0] st);
    check({tag, ".validOut"}, SW'(validOut), SW'(vo));
    check({tag, ".newBlock"}, SW'(newBlock), SW'(nb));
    check({tag, ".state"}, initialState, st);
  endtask

  task automatic step(input logic v, input logic [WW-1:0] d);
    @(negedge clk);
    ifc.writeValid = v;
    ifc.blockData  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ifc.writeValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [SW-1:0] ones;
  logic [SW-1:0] zero;
  logic [SW-1:0] exp;

  initial begin
    ones = '1;
    zero = '0;
    rst = 1'b0;
    ifc.writeValid = 1'b0;
    ifc.blockData  = '0;
    #1;
    outs("reset0", 1'b0, 1'b0, zero);

    // Continuous all-ones stream: commits at edges 11, 22, 33.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      step(1'b1, 32'hFFFF_FFFF);
      outs($sformatf("stream.e%0d", e), e >= 11,
           (e % 11) == 0, (e >= 11) ? ones : zero);
    end

    // Long idle after a commit: everything holds.
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 32'h0BAD_0BAD);
      outs($sformatf("idle.%0d", i), 1'b1, 1'b0, ones);
    end

    // Gapped words 1..11.
    do_reset();
    exp = '0;
    for (int k = 1; k <= 11; k++) begin
      exp = {exp[SW-WW-1:0], WW'(k)};
      step(1'b1, WW'(k));
      check($sformatf("gap.nb%0d", k), SW'(newBlock), SW'(k == 11));
      check($sformatf("gap.vo%0d", k), SW'(validOut), SW'(k == 11));
      step(1'b0, 32'hDEAD_BEEF);
      check($sformatf("gap.nbz%0d", k), SW'(newBlock), '0);
    end
    check("gap.state", initialState, exp);
    check("gap.hi", SW'(initialState[351:320]), SW'(1));
    check("gap.lo", SW'(initialState[31:0]), SW'(11));

    // Partial block discarded by reset.
    for (int k = 0; k < 5; k++) step(1'b1, 32'h1234_5678);
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      step(1'b1, 32'hA5A5_A5A5);
      check($sformatf("part.nb%0d", k), SW'(newBlock), SW'(k == 11));
      check($sformatf("part.vo%0d", k), SW'(validOut), SW'(k == 11));
    end
    check("part.state", initialState, {NW{32'hA5A5_A5A5}});

    // Asynchronous reset between edges right after a commit.
    #2;
    check("async.pre_nb", SW'(newBlock), SW'(1));
    rst = 1'b0;
    #1;
    outs("async", 1'b0, 1'b0, zero);

    // Words offered during reset are ignored.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h0000_0007);
    outs("inrst", 1'b0, 1'b0, zero);
    @(negedge clk);
    rst = 1'b1;
    ifc.writeValid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step(1'b1, 32'hC3C3_C3C3);
      check($sformatf("post.nb%0d", k), SW'(newBlock), SW'(k == 11));
    end
    check("post.state", initialState, {NW{32'hC3C3_C3C3}});
    step(1'b0, 32'h0);
    outs("post.hold", 1'b1, 1'b0, {NW{32'hC3C3_C3C3}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_storage.md
BLOCK_STORAGE -- requirements
Module: block_storage

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of one blockData write word.
REQ-002 Parameter NUM_WORDS, default 11, words per block; STATE_WIDTH = WORD_WIDTH*NUM_WORDS = 352.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 blkRd  interface blockStoreIfc (reader modport)  write channel into the block.
REQ-007 blkRd.writeValid  input  1  qualifies blkRd.blockData for the current cycle.
REQ-008 blkRd.blockData  input  WORD_WIDTH  one block-header word.
REQ-009 validOut  output  1  initialState holds a complete committed block.
REQ-010 newBlock  output  1  one-cycle pulse on each block commit.
REQ-011 initialState  output  STATE_WIDTH (352)  committed block state (256-bit midstate + 96-bit header tail).
REQ-012 blockStoreIfc SHALL be a separately defined interface declaring writeValid and blockData (WORD_WIDTH), with modport writer (outputs) and modport reader (inputs).

Function
REQ-013 The block SHALL hold a STATE_WIDTH assembly buffer, a word counter 0..NUM_WORDS-1, and a separate STATE_WIDTH output register driving initialState.
REQ-014 On a rising edge with writeValid=1, the buffer SHALL shift left by WORD_WIDTH and load blockData into bits [WORD_WIDTH-1:0]; the first word of a block therefore ends in bits [351:320].
REQ-015 On a rising edge with writeValid=0, buffer, counter and outputs SHALL hold, except newBlock, which SHALL return to 0.
REQ-016 Counter SHALL increment on each accepted word and wrap from NUM_WORDS-1 to 0.
REQ-017 When the accepted word is word NUM_WORDS-1, the same edge SHALL load initialState with the completed value {buffer[STATE_WIDTH-WORD_WIDTH-1:0], blockData}, set validOut=1 and set newBlock=1.
REQ-018 newBlock SHALL be 1 for exactly one cycle per commit and 0 otherwise; there is no output-side handshake.
REQ-019 initialState SHALL change only on a commit and stay stable while the next block assembles.
REQ-020 validOut SHALL remain 1 after the first commit until reset.
REQ-021 With writeValid held at 1, commits SHALL occur every NUM_WORDS cycles, giving back-to-back newBlock pulses NUM_WORDS cycles apart.
REQ-022 Gaps in writeValid SHALL pause assembly without losing words; the 11 words need not be consecutive.
REQ-023 The design SHALL have no combinational path from inputs to outputs; all outputs are registered.

Reset
REQ-024 rst=0 SHALL immediately, regardless of clk, clear the buffer, counter, initialState (all 0), validOut=0 and newBlock=0.
REQ-025 Reset mid-block SHALL discard the partial words; the next accepted word after release is word 0.
REQ-026 Words presented while rst=0 SHALL be ignored; the first accepted word is at the first rising edge with rst=1.

Verification
REQ-027 Reset pulse, then writeValid=1, blockData=32'hFFFFFFFF continuously -> validOut=0, newBlock=0, initialState=0 through edge 10; at edge 11 newBlock=1, validOut=1, initialState=all-ones; newBlock=0 at edge 12.
REQ-028 Same stimulus continued -> newBlock pulses again at edges 22 and 33; initialState stays all-ones; validOut stays 1.
REQ-029 Words 1..11 (blockData=k) with writeValid toggling 1/0 each cycle -> a single commit on the 11th accepted word; initialState[351:320]=1, initialState[31:0]=11.
REQ-030 5 words accepted, assert rst, release, then 11 words of 32'hA5A5A5A5 -> no commit before the 11th post-reset word; then initialState = A5 pattern throughout.
REQ-031 rst asserted between clock edges after a commit -> validOut, newBlock and initialState go to 0 without waiting for a clock edge.
REQ-032 writeValid=0 for 50 cycles after a commit -> outputs hold; newBlock=0 throughout.
